// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings, FSM state type and lane helpers for the
//               data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] c_WSEL_BYTE = 2'b00;
    localparam logic [1:0] c_WSEL_HALF = 2'b01;
    localparam logic [1:0] c_WSEL_WORD = 2'b10;

    localparam logic [2:0] c_RSEL_LB  = 3'b000;
    localparam logic [2:0] c_RSEL_LH  = 3'b010;
    localparam logic [2:0] c_RSEL_LW  = 3'b011;
    localparam logic [2:0] c_RSEL_LBU = 3'b100;
    localparam logic [2:0] c_RSEL_LHU = 3'b101;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                              input logic [2:0]  rsel,
                                              input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (rsel)
            c_RSEL_LB:  r = {{24{b[7]}}, b};
            c_RSEL_LH:  r = {{16{h[15]}}, h};
            c_RSEL_LBU: r = {24'h0, b};
            c_RSEL_LHU: r = {16'h0, h};
            default:    r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  wsel,
                                             input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (wsel)
            c_WSEL_BYTE: r[{lane, 3'b000} +: 8]      = wdata[7:0];
            c_WSEL_HALF: r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default:     r = wdata;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port word-wide synchronous RAM, one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_dout;

    // Read-before-write: dout returns the old contents on a write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= din;
        end
        r_dout <= r_mem[idx];
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Load/store responder with read-modify-write sub-word stores.
//               Macro DMEM_MISALIGN_TRAP_EN rejects misaligned half/word
//               accesses instead of forcing the low address bits to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        MemRW,
    input  logic [1:0]  WSel,
    input  logic [2:0]  RSel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    import dmem_pkg::*;

    state_t        r_state;
    state_t        w_next;
    logic          r_store;
    logic [1:0]    r_wsel;
    logic [2:0]    r_rsel;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic [31:0]   r_wword;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_legal;
    logic [1:0]    w_size;
    logic [1:0]    w_lane;
    logic          w_reject;
    logic          w_accept;
    logic          w_we;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_ram_dout;
    logic          w_unused_addr;

    assign w_unused_addr = &{1'b0, addr[31:AW+2]};

    // Decode of the live request; only meaningful while IDLE.
    always_comb begin
        w_legal = 1'b1;
        w_size  = c_SZ_BYTE;
        if (MemRW) begin
            case (WSel)
                c_WSEL_BYTE: w_size = c_SZ_BYTE;
                c_WSEL_HALF: w_size = c_SZ_HALF;
                c_WSEL_WORD: w_size = c_SZ_WORD;
                default:     w_legal = 1'b0;
            endcase
        end else begin
            case (RSel)
                c_RSEL_LB, c_RSEL_LBU: w_size = c_SZ_BYTE;
                c_RSEL_LH, c_RSEL_LHU: w_size = c_SZ_HALF;
                c_RSEL_LW:             w_size = c_SZ_WORD;
                default:               w_legal = 1'b0;
            endcase
        end

        w_lane = addr[1:0];
        if (w_size == c_SZ_HALF) begin
            w_lane = {addr[1], 1'b0};
        end else if (w_size == c_SZ_WORD) begin
            w_lane = 2'b00;
        end

`ifdef DMEM_MISALIGN_TRAP_EN
        w_reject = !w_legal ||
                   ((w_size == c_SZ_HALF) && addr[0]) ||
                   ((w_size == c_SZ_WORD) && (addr[1:0] != 2'b00));
`else
        w_reject = !w_legal;
`endif
    end

    assign w_accept = (r_state == IDLE) && req;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_reject) begin
                        w_next = RESP;
                    end else if (MemRW && (WSel == c_WSEL_WORD)) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:      w_next = r_store ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_store <= 1'b0;
            r_wsel  <= 2'b00;
            r_rsel  <= 3'b000;
            r_idx   <= '0;
            r_lane  <= 2'b00;
            r_wword <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_store <= MemRW;
                r_wsel  <= WSel;
                r_rsel  <= RSel;
                r_idx   <= addr[AW+1:2];
                r_lane  <= w_lane;
                r_wword <= wdata;
                if (w_reject) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == RD) begin
                if (r_store) begin
                    r_wword <= st_merge(w_ram_dout, r_wword, r_wsel, r_lane);
                end else begin
                    r_rdata <= ld_extend(w_ram_dout, r_rsel, r_lane);
                    r_err   <= 1'b0;
                end
            end
            if (r_state == WR) begin
                r_err <= 1'b0;
            end
        end
    end

    // The read is launched from the live address in IDLE so the word is
    // already on dout during RD.
    assign w_ram_idx = (r_state == IDLE) ? addr[AW+1:2] : r_idx;
    assign w_we      = (r_state == WR) && !rst;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk  (clk),
        .we   (w_we),
        .idx  (w_ram_idx),
        .din  (r_wword),
        .dout (w_ram_dout)
    );

    assign rdata = r_rdata;
    assign err   = r_err;
    assign busy  = (r_state != IDLE);
    assign done  = (r_state == RESP);

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Scoreboard bench for dmem_ctrl (honours DMEM_MISALIGN_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        MemRW;
    logic [1:0]  WSel;
    logic [2:0]  RSel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .MemRW (MemRW),
        .WSel  (WSel),
        .RSel  (RSel),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] m_rdata;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model is evaluated at drive time and queued.
    task automatic txn(input bit st, input logic [1:0] ws, input logic [2:0] rs,
                       input logic [31:0] a, input logic [31:0] wd, input bit poke);
        exp_t        e;
        exp_t        got;
        int          sz;
        int          idx;
        int          sh_amt;
        int          lat;
        bit          legal;
        bit          mis;
        bit          rej;
        bit          seen;
        logic [31:0] ae;
        logic [31:0] old;
        logic [31:0] sh;
        logic [31:0] msk;

        legal = st ? (ws != 2'b11)
                   : (rs == 3'd0 || rs == 3'd2 || rs == 3'd3 || rs == 3'd4 || rs == 3'd5);
        if (st) sz = (ws == 2'b00) ? 0 : (ws == 2'b01) ? 1 : 2;
        else    sz = (rs == 3'd3) ? 2 : (rs == 3'd2 || rs == 3'd5) ? 1 : 0;
        mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_TRAP_EN
        rej = !legal || mis;
`else
        rej = !legal;
`endif
        ae     = (sz == 1) ? (a & ~32'h1) : (sz == 2) ? (a & ~32'h3) : a;
        idx    = int'((ae >> 2) % DEPTH);
        sh_amt = 8 * int'(ae[1:0]);
        old    = mem_m[idx];
        sh     = old >> sh_amt;
        e.err   = rej;
        e.rdata = m_rdata;
        if (rej) begin
            e.lat = 1;
        end else if (!st) begin
            e.lat = 2;
            case (rs)
                3'd0:    e.rdata = {{24{sh[7]}}, sh[7:0]};
                3'd4:    e.rdata = {24'h0, sh[7:0]};
                3'd2:    e.rdata = {{16{sh[15]}}, sh[15:0]};
                3'd5:    e.rdata = {16'h0, sh[15:0]};
                default: e.rdata = old;
            endcase
            m_rdata = e.rdata;
        end else begin
            e.lat = (sz == 2) ? 2 : 3;
            if (sz == 2) begin
                mem_m[idx] = wd;
            end else begin
                msk = ((sz == 1) ? 32'h0000FFFF : 32'h000000FF) << sh_amt;
                mem_m[idx] = (old & ~msk) | ((wd << sh_amt) & msk);
            end
        end
        sb.push_back(e);

        req   = 1'b1;
        MemRW = st;
        WSel  = ws;
        RSel  = rs;
        addr  = a;
        wdata = wd;
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("busy_n1", {31'h0, busy}, 32'h1);
                req   = 1'b0;
                MemRW = ~st;
                WSel  = 2'($urandom);
                RSel  = 3'($urandom);
                addr  = $urandom;
                wdata = $urandom;
                if (poke) begin
                    req   = 1'b1;
                    MemRW = 1'b1;
                    WSel  = 2'b10;
                    addr  = 32'h40;
                end
            end else begin
                req = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        req = 1'b0;
        got = sb.pop_front();
        if (!seen) begin
            chk("done_timeout", 32'h0, 32'h1);
        end else begin
            chk("done_lat", 32'(lat), 32'(got.lat));
            chk("err", {31'h0, err}, {31'h0, got.err});
            chk("rdata", rdata, got.rdata);
        end
        @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("done_pulse", {31'h0, done}, 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        MemRW = 1'b0;
        WSel  = 2'b00;
        RSel  = 3'b000;
        addr  = 32'h0;
        wdata = 32'h0;
        m_rdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'h0, busy}, 32'h0);
        chk("rst_done",  {31'h0, done}, 32'h0);
        chk("rst_err",   {31'h0, err},  32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b1, 2'b10, 3'd0, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 2'b00, 3'd3, 32'h10, 32'h0, 1'b0);
        txn(1'b1, 2'b00, 3'd0, 32'h11, 32'h000000A5, 1'b0);
        txn(1'b0, 2'b00, 3'd3, 32'h10, 32'h0, 1'b0);

        txn(1'b1, 2'b10, 3'd0, 32'h20, 32'h80FF7F01, 1'b0);
        txn(1'b0, 2'b00, 3'd0, 32'h23, 32'h0, 1'b0);
        txn(1'b0, 2'b00, 3'd4, 32'h23, 32'h0, 1'b0);
        txn(1'b0, 2'b00, 3'd2, 32'h22, 32'h0, 1'b0);
        txn(1'b0, 2'b00, 3'd5, 32'h20, 32'h0, 1'b0);

        txn(1'b0, 2'b00, 3'd3, 32'h12, 32'h0, 1'b0);
        txn(1'b0, 2'b00, 3'd3, 32'h10, 32'h0, 1'b0);
        txn(1'b0, 2'b00, 3'd7, 32'h10, 32'h0, 1'b0);
        txn(1'b1, 2'b11, 3'd0, 32'h10, 32'h11111111, 1'b0);
        txn(1'b1, 2'b01, 3'd0, 32'h21, 32'h0000BEEF, 1'b0);
        txn(1'b0, 2'b00, 3'd3, 32'h20, 32'h0, 1'b0);

        // req pulsed while busy must not turn into a store to 0x40.
        txn(1'b1, 2'b10, 3'd0, 32'h40, 32'h55AA55AA, 1'b0);
        txn(1'b0, 2'b00, 3'd3, 32'h40, 32'h0, 1'b1);
        txn(1'b0, 2'b00, 3'd3, 32'h40, 32'h0, 1'b0);

        // Reset landing in WR suppresses the write.
        txn(1'b1, 2'b10, 3'd0, 32'h0, 32'hCAFEF00D, 1'b0);
        req   = 1'b1;
        MemRW = 1'b1;
        WSel  = 2'b10;
        addr  = 32'h0;
        wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rdata = 32'h0;
        chk("wr_rst_busy",  {31'h0, busy}, 32'h0);
        chk("wr_rst_rdata", rdata, 32'h0);
        txn(1'b0, 2'b00, 3'd3, 32'h0, 32'h0, 1'b0);

        txn(1'b1, 2'b10, 3'd0, 32'h1000, 32'h00000001, 1'b0);
        txn(1'b0, 2'b00, 3'd3, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 16; i++) txn(1'b1, 2'b10, 3'd0, 32'h100 + 32'(4 * i), $urandom, 1'b0);
        for (int i = 0; i < 24; i++)
            txn(1'($urandom), 2'($urandom), 3'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
